rx_phase_ctrl: RTL and testbench

Symbol-timing acquisition controller for the QPSK receive path. It watches the matched-filter output stream at the upsampled rate and accumulates |sample| separately for each of the UPSAMPLE sampling phases over a window of NSYMB symbols. It then selects the phase with maximum energy and presents it as the phase select for the rx slicer, with a valid flag. Acquisition starts on a start pulse, runs once, and the result is held until the next start.

---
 rtl/rx_phase_ctrl_pkg.sv | 13 +
 rtl/rx_phase_energy_acc.sv | 37 +++
 rtl/rx_phase_ctrl.sv | 112 +++++++++++
 tb/tb_rx_phase_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rx_phase_ctrl_pkg.sv
// Shared defaults for the QPSK rx/tx path and the phase-acquisition FSM encoding.
package rx_phase_ctrl_pkg;
    localparam int UPSAMPLE_DEF   = 4;
    localparam int DATA_NBITS_DEF = 8;
    localparam int NSYMB_DEF      = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/rx_phase_energy_acc.sv
// Per-phase |sample| accumulator bank with synchronous clear and a read mux.
module rx_phase_energy_acc #(
    parameter int UPSAMPLE   = 4,
    parameter int DATA_NBITS = 8,
    parameter int ACC_NBITS  = 15,
    parameter int PW         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         acc_en,
    input  logic [PW-1:0]                wr_idx,
    input  logic signed [DATA_NBITS-1:0] sample,
    input  logic [PW-1:0]                rd_idx,
    output logic [ACC_NBITS-1:0]         rd_val
);
    logic [DATA_NBITS-1:0]                mag;
    logic [UPSAMPLE-1:0][ACC_NBITS-1:0]   acc;

    // Negating the most negative code wraps to 2^(N-1), which is the exact unsigned magnitude.
    assign mag = sample[DATA_NBITS-1] ? DATA_NBITS'(-sample) : DATA_NBITS'(sample);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            for (int g = 0; g < UPSAMPLE; g++) begin
                if (wr_idx == PW'(g))
                    acc[g] <= acc[g] + ACC_NBITS'(mag);
            end
        end
    end

    assign rd_val = acc[rd_idx];
endmodule

// File: rtl/rx_phase_ctrl.sv
// Symbol-timing acquisition: per-phase energy over NSYMB symbols, then argmax as phase select.
module rx_phase_ctrl
    import rx_phase_ctrl_pkg::*;
#(
    parameter int UPSAMPLE   = UPSAMPLE_DEF,
    parameter int DATA_NBITS = DATA_NBITS_DEF,
    parameter int NSYMB      = NSYMB_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          start,
    input  logic signed [DATA_NBITS-1:0]  sample_in,
    output logic [$clog2(UPSAMPLE)-1:0]   phase_out,
    output logic                          phase_valid,
    output logic                          busy
);
    localparam int ACC_NBITS = DATA_NBITS + $clog2(NSYMB);
    localparam int PW        = $clog2(UPSAMPLE);
    localparam int SW        = (NSYMB > 1) ? $clog2(NSYMB) : 1;

    state_t                state;
    logic [PW-1:0]         phase_cnt;
    logic [SW-1:0]         symb_cnt;
    logic [PW-1:0]         best_idx;
    logic [ACC_NBITS-1:0]  best_val;
    logic [ACC_NBITS-1:0]  rd_val;
    logic                  acc_clear;
    logic                  acc_en;
    logic                  last_phase;

    assign acc_clear  = (state == ST_IDLE) && start;
    assign acc_en     = (state == ST_ACQ) && enable;
    assign last_phase = (phase_cnt == PW'(UPSAMPLE - 1));

    // phase_cnt doubles as the write index in ACQ and the compare index in CMP.
    rx_phase_energy_acc #(
        .UPSAMPLE  (UPSAMPLE),
        .DATA_NBITS(DATA_NBITS),
        .ACC_NBITS (ACC_NBITS),
        .PW        (PW)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .acc_en(acc_en),
        .wr_idx(phase_cnt),
        .sample(sample_in),
        .rd_idx(phase_cnt),
        .rd_val(rd_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            symb_cnt    <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_ACQ;
                        phase_cnt   <= '0;
                        symb_cnt    <= '0;
                        best_idx    <= '0;
                        best_val    <= '0;
                        busy        <= 1'b1;
                        phase_valid <= 1'b0;
                    end
                end
                ST_ACQ: begin
                    if (enable) begin
                        if (last_phase) begin
                            phase_cnt <= '0;
                            if (symb_cnt == SW'(NSYMB - 1))
                                state <= ST_CMP;
                            else
                                symb_cnt <= symb_cnt + 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                end
                ST_CMP: begin
                    // Strict compare keeps the lowest phase on ties.
                    if (rd_val > best_val) begin
                        best_val <= rd_val;
                        best_idx <= phase_cnt;
                    end
                    if (last_phase) begin
                        phase_cnt <= '0;
                        state     <= ST_DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    phase_out   <= best_idx;
                    phase_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_phase_ctrl.sv
// Randomized bench for rx_phase_ctrl against a per-phase energy/argmax reference model.
module tb_rx_phase_ctrl;
    localparam int U = 4;
    localparam int D = 8;
    localparam int N = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 start;
    logic signed [D-1:0]  sample_in;
    logic [1:0]           phase_out;
    logic                 phase_valid;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rx_phase_ctrl #(.UPSAMPLE(U), .DATA_NBITS(D), .NSYMB(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .start      (start),
        .sample_in  (sample_in),
        .phase_out  (phase_out),
        .phase_valid(phase_valid),
        .busy       (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int gen(input int mode, input int ph);
        case (mode)
            0: return (ph == 2) ? 100 : 10;
            1: return (ph == 1) ? -128 : 127;
            2: return 50;
            3: return 0;
            4: return (ph == 3) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 180)) - 90;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; start is driven in this very cycle.
    task automatic run_acq(input int mode, input bit gappy, input bit extra, output int exp_ph);
        int  e[U];
        int  n, cnt, s, bv;
        bit  en;
        for (int i = 0; i < U; i++) e[i] = 0;
        start     = 1'b1;
        enable    = 1'b1;
        sample_in = 8'sd127;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", busy, 1);
        chk("valid_clr", phase_valid, 0);
        n = 0;
        while (n < U * N) begin
            en        = gappy ? bit'($urandom_range(0, 1)) : 1'b1;
            s         = gen(mode, n % U);
            enable    = en;
            sample_in = 8'(s);
            start     = extra && ($urandom_range(0, 3) == 0);
            if (en) begin
                e[n % U] += iabs(s);
                n++;
            end
            @(negedge clk);
            chk("busy_acq", busy, 1);
        end
        cnt = 0;
        while (!phase_valid && cnt < 20) begin
            chk("busy_cmp", busy, 1);
            enable    = bit'($urandom_range(0, 1));
            sample_in = 8'($urandom);
            start     = extra && ($urandom_range(0, 1) == 0);
            @(negedge clk);
            cnt++;
        end
        start  = 1'b0;
        enable = 1'b0;
        exp_ph = 0;
        bv     = 0;
        for (int i = 0; i < U; i++) begin
            if (e[i] > bv) begin
                bv     = e[i];
                exp_ph = i;
            end
        end
        chk("latency", cnt, U + 1);
        chk("phase", int'(phase_out), exp_ph);
        chk("valid", phase_valid, 1);
        chk("busy_off", busy, 0);
    endtask

    task automatic hold_chk(input int exp_ph);
        for (int i = 0; i < 3; i++) begin
            enable    = bit'($urandom_range(0, 1));
            sample_in = 8'($urandom);
            @(negedge clk);
            chk("hold_phase", int'(phase_out), exp_ph);
            chk("hold_valid", phase_valid, 1);
        end
        enable = 1'b0;
    endtask

    initial begin
        int ph;
        rst       = 1'b1;
        enable    = 1'b0;
        start     = 1'b0;
        sample_in = '0;
        #12;
        chk("rst_phase", int'(phase_out), 0);
        chk("rst_valid", phase_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_acq(0, 1'b0, 1'b0, ph); chk("dominant2", ph, 2); hold_chk(ph);
        run_acq(1, 1'b0, 1'b0, ph); chk("sign", ph, 1);
        run_acq(2, 1'b0, 1'b0, ph); chk("tie", ph, 0);
        run_acq(3, 1'b0, 1'b0, ph); chk("zero", ph, 0); hold_chk(ph);
        run_acq(0, 1'b1, 1'b1, ph); chk("gaps", ph, 2);

        // asynchronous reset clears a held result immediately
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", int'(phase_out), 0);
        chk("arst_valid", phase_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // abort in ACQ after 10 samples
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample_in = 8'(gen(5, i % U));
            @(negedge clk);
        end
        enable = 1'b0;
        chk("abort_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", phase_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_acq(4, 1'b1, 1'b0, ph); chk("dominant3", ph, 3); hold_chk(ph);
        for (int k = 0; k < 6; k++) begin
            run_acq(5, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ph);
            if (k % 2 == 1) hold_chk(ph);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
